// File: rtl/txn_packer.sv
// txn_packer: assembles a 1+2*DEP_BEATS beat host stream into one wide transaction.
// Malformed frames are dropped and counted, never forwarded.
module txn_packer #(
    parameter int BEAT_WIDTH = 64,
    parameter int DEP_WIDTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [BEAT_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [BEAT_WIDTH-1:0] m_axis_tdata_owner_programID,
    output logic [DEP_WIDTH-1:0]  m_axis_tdata_read_dependencies,
    output logic [DEP_WIDTH-1:0]  m_axis_tdata_write_dependencies,
    output logic                  frame_error,
    output logic [31:0]           packets_sent,
    output logic [31:0]           packets_dropped
);
    localparam int DEP_BEATS = DEP_WIDTH / BEAT_WIDTH;
    localparam int CW = DEP_BEATS > 1 ? $clog2(DEP_BEATS) : 1;
    typedef enum logic [2:0] {HDR, RD, WR, SEND, DRAIN} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic beat, last_dep, err;
    assign s_axis_tready = state != SEND;
    assign beat = s_axis_tvalid && s_axis_tready;
    assign last_dep = cnt == CW'(DEP_BEATS - 1);
    // a long frame errors once, on its final write beat; drained beats never error
    assign err = beat && (state == WR ? (last_dep ? !s_axis_tlast : s_axis_tlast)
                                      : (state == HDR || state == RD) && s_axis_tlast);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR;
            cnt <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata_owner_programID <= '0;
            m_axis_tdata_read_dependencies <= '0;
            m_axis_tdata_write_dependencies <= '0;
            frame_error <= 1'b0;
            packets_sent <= '0;
            packets_dropped <= '0;
        end else begin
            frame_error <= err;
            if (err) packets_dropped <= packets_dropped + 32'd1;
            if (beat) begin
                case (state)
                    HDR: begin
                        m_axis_tdata_owner_programID <= s_axis_tdata;
                        cnt <= '0;
                        state <= s_axis_tlast ? HDR : RD;
                    end
                    RD: begin
                        m_axis_tdata_read_dependencies[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= s_axis_tdata;
                        cnt <= last_dep ? '0 : cnt + 1'b1;
                        state <= s_axis_tlast ? HDR : last_dep ? WR : RD;
                    end
                    WR: begin
                        m_axis_tdata_write_dependencies[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= s_axis_tdata;
                        cnt <= cnt + 1'b1;
                        m_axis_tvalid <= last_dep && s_axis_tlast;
                        state <= last_dep ? (s_axis_tlast ? SEND : DRAIN) : (s_axis_tlast ? HDR : WR);
                    end
                    DRAIN: state <= s_axis_tlast ? HDR : DRAIN;
                    default: ;
                endcase
            end
            if (state == SEND && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                packets_sent <= packets_sent + 32'd1;
                state <= HDR;
            end
        end
    end
endmodule

// File: tb/tb_txn_packer.sv
// tb_txn_packer: directed scenario tests for txn_packer with hand-computed expectations.
module tb_txn_packer;
    localparam int BW = 64;
    localparam int DW = 1024;
    localparam int DB = DW / BW;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [BW-1:0] s_tdata = '0;
    logic m_tvalid, m_tready = 1'b0;
    logic [BW-1:0] prog;
    logic [DW-1:0] rd, wr, exp_rd, exp_wr;
    logic frame_error;
    logic [31:0] sent, dropped;
    int checks = 0, failures = 0, pulses = 0;

    txn_packer #(.BEAT_WIDTH(BW), .DEP_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata_owner_programID(prog),
        .m_axis_tdata_read_dependencies(rd),
        .m_axis_tdata_write_dependencies(wr),
        .frame_error(frame_error), .packets_sent(sent), .packets_dropped(dropped)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (frame_error === 1'b1) pulses++;

    // beat 0 is the header, 1..16 read beats, 17..32 write beats, beyond that filler
    function automatic logic [BW-1:0] beat_val(input logic [BW-1:0] hdr, input int i);
        if (i == 0) return hdr;
        if (i <= DB) return BW'(i);
        if (i <= 2 * DB) return BW'(64'h100 + 64'(i - DB));
        return BW'(64'hDEAD_0000 + 64'(i));
    endfunction

    // called just after a rising edge; returns #1 after the edge of the last driven beat
    task automatic send_beats(input logic [BW-1:0] hdr, input int n, input int from, input int to);
        for (int i = from; i < to; i++) begin
            s_tvalid = 1'b1;
            s_tdata = beat_val(hdr, i);
            s_tlast = (i == n - 1);
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({m_tvalid, frame_error, sent, dropped} !== 66'd0 || prog !== '0 || rd !== '0 || wr !== '0) begin
            failures++;
            $display("FAIL reset_values tvalid=%b err=%b sent=%0d dropped=%0d prog=%h required all zero",
                     m_tvalid, frame_error, sent, dropped, prog);
        end
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_tready got=%b required=1", s_tready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame(input logic [BW-1:0] hdr, input int es, input int ed);
        m_tready = 1'b1;
        send_beats(hdr, 2 * DB + 1, 0, 2 * DB);
        checks++;
        if (m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL good_early_valid hdr=%h got=%b required=0", hdr, m_tvalid);
        end
        send_beats(hdr, 2 * DB + 1, 2 * DB, 2 * DB + 1);
        checks++;
        if (m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
            failures++;
            $display("FAIL good_latency hdr=%h tvalid=%b s_tready=%b required 1/0", hdr, m_tvalid, s_tready);
        end
        checks++;
        if (prog !== hdr || rd !== exp_rd || wr !== exp_wr) begin
            failures++;
            $display("FAIL good_data prog=%h required=%h rd_lo=%h rd_hi=%h wr_lo=%h wr_hi=%h",
                     prog, hdr, rd[63:0], rd[DW-1 -: 64], wr[63:0], wr[DW-1 -: 64]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || sent !== 32'(es) || dropped !== 32'(ed) || s_tready !== 1'b1) begin
            failures++;
            $display("FAIL good_done hdr=%h tvalid=%b sent=%0d dropped=%0d s_tready=%b required 0/%0d/%0d/1",
                     hdr, m_tvalid, sent, dropped, s_tready, es, ed);
        end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        m_tready = 1'b0;
        send_beats(64'hA5, 2 * DB + 1, 0, 2 * DB + 1);
        for (int c = 0; c < 20; c++) begin
            if (m_tvalid !== 1'b1 || s_tready !== 1'b0 || prog !== 64'hA5 || rd !== exp_rd ||
                wr !== exp_wr || sent !== 32'd1) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold unstable_cycles=%0d required=0", bad);
        end
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || sent !== 32'd2 || s_tready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release tvalid=%b sent=%0d s_tready=%b required 0/2/1",
                     m_tvalid, sent, s_tready);
        end
    endtask

    task automatic test_short;
        int p0 = pulses;
        send_beats(64'h5, 6, 0, 6);
        checks++;
        if (frame_error !== 1'b1 || dropped !== 32'd1) begin
            failures++;
            $display("FAIL short_pulse err=%b dropped=%0d required 1/1", frame_error, dropped);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_error !== 1'b0 || m_tvalid !== 1'b0 || pulses - p0 != 1) begin
            failures++;
            $display("FAIL short_after err=%b tvalid=%b pulses=%0d required 0/0/1",
                     frame_error, m_tvalid, pulses - p0);
        end
        test_good_frame(64'hB6, 3, 1);
    endtask

    task automatic test_long;
        int p0 = pulses;
        send_beats(64'hC7, 2 * DB + 4, 0, 2 * DB + 1);
        checks++;
        if (frame_error !== 1'b1 || m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            failures++;
            $display("FAIL long_detect err=%b tvalid=%b s_tready=%b required 1/0/1", frame_error, m_tvalid, s_tready);
        end
        send_beats(64'hC7, 2 * DB + 4, 2 * DB + 1, 2 * DB + 4);
        @(posedge clk);
        #1;
        checks++;
        if (dropped !== 32'd2 || m_tvalid !== 1'b0 || sent !== 32'd3 || pulses - p0 != 1) begin
            failures++;
            $display("FAIL long_drain dropped=%0d tvalid=%b sent=%0d pulses=%0d required 2/0/3/1",
                     dropped, m_tvalid, sent, pulses - p0);
        end
        test_good_frame(64'hC8, 4, 2);
    endtask

    task automatic test_header_only;
        send_beats(64'hD8, 1, 0, 1);
        checks++;
        if (frame_error !== 1'b1 || dropped !== 32'd3 || s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL header_only err=%b dropped=%0d s_tready=%b tvalid=%b required 1/3/1/0",
                     frame_error, dropped, s_tready, m_tvalid);
        end
        test_good_frame(64'hD9, 5, 3);
    endtask

    task automatic test_reset_midframe;
        m_tready = 1'b0;
        send_beats(64'hE9, 2 * DB + 1, 0, 2 * DB + 1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || sent !== 32'd0) begin
            failures++;
            $display("FAIL reset_in_send tvalid=%b sent=%0d required 0/0", m_tvalid, sent);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beats(64'hF0, 2 * DB + 1, 0, DB + 8);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_tvalid, frame_error, sent, dropped} !== 66'd0 || prog !== '0 || rd !== '0 || wr !== '0) begin
            failures++;
            $display("FAIL reset_midframe tvalid=%b err=%b sent=%0d dropped=%0d prog=%h required all zero",
                     m_tvalid, frame_error, sent, dropped, prog);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_good_frame(64'hF1, 1, 0);
    endtask

    initial begin
        for (int i = 0; i < DB; i++) begin
            exp_rd[i*BW +: BW] = BW'(i + 1);
            exp_wr[i*BW +: BW] = BW'(64'h101 + 64'(i));
        end
        test_reset;
        test_good_frame(64'hA5, 1, 0);
        test_backpressure;
        test_short;
        test_long;
        test_header_only;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
